reg_file_nxw: RTL and testbench



---
 rtl/reg_file_nxw.sv | 108 ++++++++++
 tb/tb_reg_file_nxw.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_nxw.sv
// reg_file_nxw
//   DEPTH x WIDTH register file: one synchronous write port, two combinational
//   read ports, synchronous bank clear, optional write-through bypass and
//   optional hard-wired zero word 0. Sits between the ALU result bus and the
//   ALU operand inputs.
//
//   Parameters
//     WIDTH   data width of every word
//     DEPTH   number of words (2..2**ADDR_W)
//     ADDR_W  address width
//     BYPASS  1: a read of the address being written returns w_data this cycle
//     ZERO_R0 1: word 0 always reads 0 and ignores writes
//
//   Ports
//     clock     rising-edge clock
//     reset     asynchronous, active-high; clears every word
//     clr       synchronous clear of all words (beats we)
//     we        write enable
//     w_addr    write address
//     w_data    write data
//     r_addr_a  read address, port A
//     r_addr_b  read address, port B
//     r_data_a  read data, port A (combinational)
//     r_data_b  read data, port B (combinational)
//
//   Handshake: none. One write is accepted on every clock edge where we = 1;
//   there is no valid/ready pair and no back-pressure.
module reg_file_nxw #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  w_data,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [WIDTH-1:0]  r_data_a,
  output logic [WIDTH-1:0]  r_data_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // An address is writable when it is in range and is not the hard-wired
  // zero word.
  logic w_addr_in_range;
  logic w_addr_writable;
  logic wr_fire;

  assign w_addr_in_range = (32'(w_addr) < DEPTH);
  assign w_addr_writable = w_addr_in_range && !(ZERO_R0 && (w_addr == '0));
  // A clear in the same cycle suppresses the write, so it also suppresses
  // the bypass: the read shows pre-clear contents until the edge.
  assign wr_fire = we && !clr && w_addr_writable;

  // Storage. Words are updated by address compare rather than by indexing so
  // that out-of-range addresses never touch the array.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_addr == ADDR_W'(i)) mem[i] <= w_data;
      end
    end
  end

  // Stored-value lookup; out-of-range addresses return 0.
  function automatic logic [WIDTH-1:0] lookup(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) val = mem[i];
    end
    return val;
  endfunction

  // Read path: zero-word override first, then bypass mux, then storage.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    if (ZERO_R0 && (addr == '0)) begin
      val = '0;
    end else if (BYPASS && wr_fire && (w_addr == addr)) begin
      val = w_data;
    end else begin
      val = lookup(addr);
    end
    return val;
  endfunction

  always_comb begin
    r_data_a = '0;
    r_data_a = read_port(r_addr_a);
  end

  always_comb begin
    r_data_b = '0;
    r_data_b = read_port(r_addr_b);
  end

endmodule

// File: tb/tb_reg_file_nxw.sv
// Testbench for reg_file_nxw. Four instances share one set of inputs:
//   dut0: defaults (BYPASS=1, ZERO_R0=0, DEPTH=8)
//   dut1: BYPASS=0
//   dut2: ZERO_R0=1
//   dut3: DEPTH=6 (ADDR_W=3)
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// an input change or after the rising edge.
module tb_reg_file_nxw;

  logic        clock;
  logic        reset;
  logic        clr;
  logic        we;
  logic [2:0]  w_addr;
  logic [15:0] w_data;
  logic [2:0]  r_addr_a;
  logic [2:0]  r_addr_b;
  logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3;

  int n_cmp;
  int n_bad;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  reg_file_nxw #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut0 (
    .clock(clock), .reset(reset), .clr(clr), .we(we), .w_addr(w_addr), .w_data(w_data),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(a0), .r_data_b(b0));
  reg_file_nxw #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut1 (
    .clock(clock), .reset(reset), .clr(clr), .we(we), .w_addr(w_addr), .w_data(w_data),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(a1), .r_data_b(b1));
  reg_file_nxw #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut2 (
    .clock(clock), .reset(reset), .clr(clr), .we(we), .w_addr(w_addr), .w_data(w_data),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(a2), .r_data_b(b2));
  reg_file_nxw #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut3 (
    .clock(clock), .reset(reset), .clr(clr), .we(we), .w_addr(w_addr), .w_data(w_data),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(a3), .r_data_b(b3));

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clock);
    we = 1'b1; w_addr = addr; w_data = data;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    @(negedge clock);
    we = 1'b0; clr = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset_state();
    for (int k = 0; k < 8; k++) begin
      r_addr_a = 3'(k); r_addr_b = 3'(7 - k);
      #1;
      n_cmp++;
      if (a0 !== 16'h0000 || b0 !== 16'h0000 || a1 !== 16'h0000 || a2 !== 16'h0000 || a3 !== 16'h0000) begin
        n_bad++;
        $display("FAIL reset_state addr=%0d a0=%h b0=%h a1=%h a2=%h a3=%h required 0000", k, a0, b0, a1, a2, a3);
      end
    end
  endtask

  task automatic test_write_read();
    logic [15:0] ea, eb;
    for (int k = 0; k < 8; k++) write_word(3'(k), 16'(16'h1111 * k));
    idle();
    for (int k = 0; k < 8; k++) begin
      r_addr_a = 3'(k); r_addr_b = 3'(7 - k);
      #1;
      ea = 16'(16'h1111 * k);
      eb = 16'(16'h1111 * (7 - k));
      n_cmp++;
      if (a0 !== ea || b0 !== eb) begin
        n_bad++;
        $display("FAIL write_read k=%0d a=%h b=%h required a=%h b=%h", k, a0, b0, ea, eb);
      end
      n_cmp++;
      if (a2 !== ((k == 0) ? 16'h0000 : ea)) begin
        n_bad++;
        $display("FAIL write_read_zero_r0 k=%0d a=%h required %h", k, a2, (k == 0) ? 16'h0000 : ea);
      end
      n_cmp++;
      if (a3 !== ((k >= 6) ? 16'h0000 : ea)) begin
        n_bad++;
        $display("FAIL write_read_depth6 k=%0d a=%h required %h", k, a3, (k >= 6) ? 16'h0000 : ea);
      end
    end
  endtask

  task automatic test_bypass();
    write_word(3'd5, 16'h00AA);
    @(negedge clock);
    we = 1'b1; w_addr = 3'd5; w_data = 16'h1234; r_addr_a = 3'd5; r_addr_b = 3'd4;
    #1;
    n_cmp++;
    if (a0 !== 16'h1234) begin
      n_bad++; $display("FAIL bypass_on got %h required 1234", a0);
    end
    n_cmp++;
    if (a1 !== 16'h00AA) begin
      n_bad++; $display("FAIL bypass_off_before got %h required 00aa", a1);
    end
    n_cmp++;
    if (b0 !== 16'h4444) begin
      n_bad++; $display("FAIL bypass_other_port got %h required 4444", b0);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (a1 !== 16'h1234) begin
      n_bad++; $display("FAIL bypass_off_after got %h required 1234", a1);
    end
    idle();
  endtask

  task automatic test_clr_priority();
    @(negedge clock);
    clr = 1'b1; we = 1'b1; w_addr = 3'd2; w_data = 16'h5555; r_addr_a = 3'd2;
    #1;
    n_cmp++;
    if (a0 !== 16'h2222 || a1 !== 16'h2222) begin
      n_bad++; $display("FAIL clr_no_bypass a0=%h a1=%h required 2222", a0, a1);
    end
    @(posedge clock);
    idle();
    for (int k = 0; k < 8; k++) begin
      r_addr_a = 3'(k); r_addr_b = 3'(k);
      #1;
      n_cmp++;
      if (a0 !== 16'h0000 || b1 !== 16'h0000 || a2 !== 16'h0000 || a3 !== 16'h0000) begin
        n_bad++;
        $display("FAIL clr_all k=%0d a0=%h b1=%h a2=%h a3=%h required 0000", k, a0, b1, a2, a3);
      end
    end
  endtask

  task automatic test_zero_r0();
    @(negedge clock);
    we = 1'b1; w_addr = 3'd0; w_data = 16'hFFFF; r_addr_a = 3'd0;
    #1;
    n_cmp++;
    if (a2 !== 16'h0000 || a0 !== 16'hFFFF) begin
      n_bad++; $display("FAIL zero_r0_bypass a2=%h a0=%h required a2=0000 a0=ffff", a2, a0);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (a2 !== 16'h0000 || a0 !== 16'hFFFF) begin
      n_bad++; $display("FAIL zero_r0_after a2=%h a0=%h required a2=0000 a0=ffff", a2, a0);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < 6; k++) write_word(3'(k), 16'(16'hA000 + k));
    @(negedge clock);
    we = 1'b1; w_addr = 3'd6; w_data = 16'h7777; r_addr_a = 3'd6; r_addr_b = 3'd7;
    #1;
    n_cmp++;
    if (a3 !== 16'h0000 || b3 !== 16'h0000 || a0 !== 16'h7777) begin
      n_bad++; $display("FAIL oor_bypass a3=%h b3=%h a0=%h required 0000 0000 7777", a3, b3, a0);
    end
    @(posedge clock);
    idle();
    for (int k = 0; k < 8; k++) begin
      r_addr_a = 3'(k);
      #1;
      n_cmp++;
      if (a3 !== ((k >= 6) ? 16'h0000 : 16'(16'hA000 + k))) begin
        n_bad++;
        $display("FAIL oor_words k=%0d got %h required %h", k, a3, (k >= 6) ? 16'h0000 : 16'(16'hA000 + k));
      end
    end
    r_addr_a = 3'd6;
    #1;
    n_cmp++;
    if (a0 !== 16'h7777) begin
      n_bad++; $display("FAIL oor_depth8_word6 got %h required 7777", a0);
    end
  endtask

  task automatic test_reset();
    write_word(3'd3, 16'hBEEF);
    idle();
    r_addr_a = 3'd3;
    #1;
    n_cmp++;
    if (a0 !== 16'hBEEF) begin
      n_bad++; $display("FAIL reset_pre got %h required beef", a0);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (a0 !== 16'h0000 || a1 !== 16'h0000) begin
      n_bad++; $display("FAIL reset_async a0=%h a1=%h required 0000", a0, a1);
    end
    // In-flight write across an edge while reset is high is lost.
    we = 1'b1; w_addr = 3'd3; w_data = 16'h1234;
    @(posedge clock);
    #1;
    n_cmp++;
    if (a1 !== 16'h0000) begin
      n_bad++; $display("FAIL reset_wins got %h required 0000", a1);
    end
    @(negedge clock);
    we = 1'b0; reset = 1'b0;
    #1;
    n_cmp++;
    if (a0 !== 16'h0000) begin
      n_bad++; $display("FAIL reset_release got %h required 0000", a0);
    end
    // First write at the first edge after release.
    we = 1'b1; w_addr = 3'd3; w_data = 16'h0042;
    @(posedge clock);
    #1;
    n_cmp++;
    if (a1 !== 16'h0042) begin
      n_bad++; $display("FAIL reset_first_write got %h required 0042", a1);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  t_addr [3];
    logic [15:0] t_data [3];
    logic [15:0] t_old  [3];
    t_addr[0] = 3'd1; t_data[0] = 16'h0101; t_old[0] = 16'h0000;
    t_addr[1] = 3'd1; t_data[1] = 16'h0202; t_old[1] = 16'h0101;
    t_addr[2] = 3'd2; t_data[2] = 16'h0303; t_old[2] = 16'h0202;
    r_addr_b = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      we = 1'b1; w_addr = t_addr[i]; w_data = t_data[i];
      #1;
      n_cmp++;
      if (b1 !== t_old[i]) begin
        n_bad++; $display("FAIL b2b_old i=%0d got %h required %h", i, b1, t_old[i]);
      end
    end
    @(posedge clock);
    idle();
    r_addr_a = 3'd2;
    #1;
    n_cmp++;
    if (a1 !== 16'h0303 || b1 !== 16'h0202 || a0 !== 16'h0303) begin
      n_bad++; $display("FAIL b2b_final a1=%h b1=%h a0=%h required 0303 0202 0303", a1, b1, a0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; clr = 1'b0; we = 1'b0;
    w_addr = '0; w_data = '0; r_addr_a = '0; r_addr_b = '0;
    @(negedge clock);
    test_reset_state();
    @(negedge clock);
    reset = 1'b0;
    test_write_read();
    test_bypass();
    test_clr_priority();
    test_zero_r0();
    test_out_of_range();
    test_reset();
    test_back_to_back();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
